// File: rtl/dplca_txop_claim_pkg.sv
// Shared definitions for the DPLCA claim-side (transmitter) logic:
// claim encodings, boolean helpers, FSM states and the scan-index wrap helper.
package dplca_txop_claim_pkg;

    // Claim encodings as carried in the TXOP and in txop_claim_table
    localparam logic [1:0] CLAIM_SOFT = 2'b00;
    localparam logic [1:0] CLAIM_HARD = 2'b01;
    localparam logic [1:0] CLAIM_NONE = 2'b10;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;
    localparam logic ON    = 1'b1;
    localparam logic OFF   = 1'b0;

    localparam logic [7:0] NODE_ID_NONE = 8'hFF;

    typedef enum logic [2:0] {
        ST_DISABLED   = 3'd0,
        ST_SCAN       = 3'd1,
        ST_WAIT_FREE  = 3'd2,
        ST_SOFT_CLAIM = 3'd3,
        ST_HARD_CLAIM = 3'd4
    } claim_state_e;

    // Next ID to examine after idx; wraps past node_count-1 back to 1 (ID 0 is reserved).
    function automatic logic [7:0] next_scan_idx(input logic [7:0] idx,
                                                 input logic [7:0] node_count);
        logic [8:0] inc;
        inc = {1'b0, idx} + 9'd1;
        if (inc >= {1'b0, node_count}) begin
            return 8'd1;
        end else begin
            return inc[7:0];
        end
    endfunction

endpackage

// File: rtl/dplca_claim_lfsr.sv
// Free-running 8-bit Galois LFSR (x^8+x^6+x^5+x^4+1) and reduction of its
// value into the valid ID range 1..node_count-1. Used to randomise the
// starting scan index when DPLCA_RANDOM_START_EN is defined.
module dplca_claim_lfsr
    import dplca_txop_claim_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] node_count,
    output logic [7:0] start_idx
);

    logic [7:0] lfsr_r;
    logic [7:0] lfsr_next_s;
    logic [7:0] range_s;

    // Galois step: shift right, fold the tap mask in when the outgoing bit is set
    always_comb begin
        lfsr_next_s = {1'b0, lfsr_r[7:1]};
        if (lfsr_r[0] == TRUE) begin
            lfsr_next_s = {1'b0, lfsr_r[7:1]} ^ 8'hB8;
        end else begin
            lfsr_next_s = {1'b0, lfsr_r[7:1]};
        end
    end

    // LFSR state register, free-running every clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_r <= SEED;
        end else begin
            lfsr_r <= lfsr_next_s;
        end
    end

    assign range_s = node_count - 8'd1;

    // Map the LFSR value into 1..node_count-1; degenerate counts fall back to 1
    always_comb begin
        start_idx = 8'd1;
        if (node_count < 8'd2) begin
            start_idx = 8'd1;
        end else begin
            start_idx = (lfsr_r % range_s) + 8'd1;
        end
    end

endmodule

// File: rtl/dplca_txop_claim.sv
// DPLCA claim machine: picks a free TXOP ID from the learned claim table,
// advertises it SOFT, promotes it to HARD after SOFT_CYCLES clean own TXOPs,
// and abandons/re-scans on collision or when another node's HARD claim wins.
// Optional build macro: DPLCA_RANDOM_START_EN (LFSR-randomised scan start).
module dplca_txop_claim
    import dplca_txop_claim_pkg::*;
#(
    parameter int unsigned SOFT_CYCLES = 4,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         dplca_en,
    input  logic [7:0]   plca_node_count,
    input  logic         dplca_txop_end,
    input  logic [7:0]   dplca_txop_id,
    input  logic         dplca_txop_collision,
    input  logic         dplca_txop_table_upd,
    input  logic [511:0] txop_claim_table_unpacked,
    output logic [7:0]   local_nodeID,
    output logic [1:0]   local_claim,
    output logic [2:0]   claim_state,
    output logic         dplca_claim_done,
    output logic         dplca_claim_lost
);

    localparam logic [7:0] SOFT_MAX = SOFT_CYCLES[7:0];

    logic [1:0] table_s [0:255];

    genvar gi;
    generate
        for (gi = 0; gi < 256; gi++) begin : g_unpack
            assign table_s[gi] = txop_claim_table_unpacked[2*gi+1 -: 2];
        end
    endgenerate

    logic [7:0] start_idx_s;

`ifdef DPLCA_RANDOM_START_EN
    dplca_claim_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk        (clk),
        .rst_n      (rst_n),
        .node_count (plca_node_count),
        .start_idx  (start_idx_s)
    );
`else
    logic unused_seed_s;
    assign unused_seed_s = ^LFSR_SEED;
    assign start_idx_s   = 8'd1;
`endif

    claim_state_e state_r, state_n;
    logic [7:0]   scan_idx_r, scan_idx_n;
    logic [7:0]   scan_cnt_r, scan_cnt_n;
    logic [7:0]   clean_cnt_r, clean_cnt_n;
    logic [7:0]   cand_r, cand_n;
    logic [7:0]   node_id_r, node_id_n;
    logic [1:0]   claim_r, claim_n;
    logic         done_r, done_n;
    logic         lost_r, lost_n;

    logic       own_end_s;
    logic       cand_oor_s;
    logic       tbl_cand_hard_s;
    logic [7:0] scan_pos_s;
    logic [7:0] clean_inc_s;
    logic       scan_last_s;

    assign own_end_s       = dplca_txop_end && (dplca_txop_id == cand_r);
    assign cand_oor_s      = (cand_r >= plca_node_count);
    assign tbl_cand_hard_s = dplca_txop_table_upd && (table_s[cand_r] == CLAIM_HARD);
    // A stale index (node count shrank) restarts the scan at 1
    assign scan_pos_s      = ((scan_idx_r == 8'd0) || (scan_idx_r >= plca_node_count)) ?
                             8'd1 : scan_idx_r;
    assign clean_inc_s     = (clean_cnt_r >= SOFT_MAX) ? SOFT_MAX : (clean_cnt_r + 8'd1);
    assign scan_last_s     = (({1'b0, scan_cnt_r} + 9'd1) >= ({1'b0, plca_node_count} - 9'd1));

    // Next-state and next-output decision for the claim FSM
    always_comb begin
        state_n     = state_r;
        scan_idx_n  = scan_idx_r;
        scan_cnt_n  = scan_cnt_r;
        clean_cnt_n = clean_cnt_r;
        cand_n      = cand_r;
        node_id_n   = node_id_r;
        claim_n     = claim_r;
        done_n      = done_r;
        lost_n      = FALSE;

        if (dplca_en == OFF) begin
            state_n     = ST_DISABLED;
            scan_idx_n  = 8'd1;
            scan_cnt_n  = 8'd0;
            clean_cnt_n = 8'd0;
            cand_n      = NODE_ID_NONE;
            node_id_n   = NODE_ID_NONE;
            claim_n     = CLAIM_NONE;
            done_n      = FALSE;
        end else begin
            case (state_r)
                ST_DISABLED: begin
                    state_n    = ST_SCAN;
                    scan_idx_n = start_idx_s;
                    scan_cnt_n = 8'd0;
                    node_id_n  = NODE_ID_NONE;
                    claim_n    = CLAIM_NONE;
                end

                ST_SCAN: begin
                    if (plca_node_count < 8'd2) begin
                        state_n   = ST_WAIT_FREE;
                        node_id_n = NODE_ID_NONE;
                        claim_n   = CLAIM_NONE;
                    end else if (table_s[scan_pos_s] == CLAIM_NONE) begin
                        state_n     = ST_SOFT_CLAIM;
                        cand_n      = scan_pos_s;
                        node_id_n   = scan_pos_s;
                        claim_n     = CLAIM_SOFT;
                        clean_cnt_n = 8'd0;
                    end else if (scan_last_s) begin
                        state_n   = ST_WAIT_FREE;
                        node_id_n = NODE_ID_NONE;
                        claim_n   = CLAIM_NONE;
                    end else begin
                        scan_cnt_n = scan_cnt_r + 8'd1;
                        scan_idx_n = next_scan_idx(scan_pos_s, plca_node_count);
                    end
                end

                ST_WAIT_FREE: begin
                    node_id_n = NODE_ID_NONE;
                    claim_n   = CLAIM_NONE;
                    if (dplca_txop_table_upd == TRUE) begin
                        state_n    = ST_SCAN;
                        scan_idx_n = start_idx_s;
                        scan_cnt_n = 8'd0;
                    end else begin
                        state_n = ST_WAIT_FREE;
                    end
                end

                ST_SOFT_CLAIM: begin
                    // Abandon (collision, lost to a HARD claim, or ID out of range) beats a clean end
                    if ((own_end_s && dplca_txop_collision) || tbl_cand_hard_s || cand_oor_s) begin
                        state_n     = ST_SCAN;
                        scan_idx_n  = next_scan_idx(cand_r, plca_node_count);
                        scan_cnt_n  = 8'd0;
                        clean_cnt_n = 8'd0;
                        node_id_n   = NODE_ID_NONE;
                        claim_n     = CLAIM_NONE;
                        done_n      = FALSE;
                        lost_n      = TRUE;
                    end else if (own_end_s) begin
                        clean_cnt_n = clean_inc_s;
                        if (clean_inc_s >= SOFT_MAX) begin
                            state_n = ST_HARD_CLAIM;
                            claim_n = CLAIM_HARD;
                            done_n  = TRUE;
                        end else begin
                            state_n = ST_SOFT_CLAIM;
                        end
                    end else begin
                        state_n = ST_SOFT_CLAIM;
                    end
                end

                ST_HARD_CLAIM: begin
                    // Table is ignored: it holds our own HARD claim
                    if ((own_end_s && dplca_txop_collision) || cand_oor_s) begin
                        state_n     = ST_SCAN;
                        scan_idx_n  = next_scan_idx(cand_r, plca_node_count);
                        scan_cnt_n  = 8'd0;
                        clean_cnt_n = 8'd0;
                        node_id_n   = NODE_ID_NONE;
                        claim_n     = CLAIM_NONE;
                        done_n      = FALSE;
                        lost_n      = TRUE;
                    end else begin
                        state_n = ST_HARD_CLAIM;
                    end
                end

                default: begin
                    state_n     = ST_DISABLED;
                    scan_idx_n  = 8'd1;
                    scan_cnt_n  = 8'd0;
                    clean_cnt_n = 8'd0;
                    cand_n      = NODE_ID_NONE;
                    node_id_n   = NODE_ID_NONE;
                    claim_n     = CLAIM_NONE;
                    done_n      = FALSE;
                end
            endcase
        end
    end

    // State and registered-output update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_DISABLED;
            scan_idx_r  <= 8'd1;
            scan_cnt_r  <= 8'd0;
            clean_cnt_r <= 8'd0;
            cand_r      <= NODE_ID_NONE;
            node_id_r   <= NODE_ID_NONE;
            claim_r     <= CLAIM_NONE;
            done_r      <= FALSE;
            lost_r      <= FALSE;
        end else begin
            state_r     <= state_n;
            scan_idx_r  <= scan_idx_n;
            scan_cnt_r  <= scan_cnt_n;
            clean_cnt_r <= clean_cnt_n;
            cand_r      <= cand_n;
            node_id_r   <= node_id_n;
            claim_r     <= claim_n;
            done_r      <= done_n;
            lost_r      <= lost_n;
        end
    end

    assign local_nodeID     = node_id_r;
    assign local_claim      = claim_r;
    assign claim_state      = state_r;
    assign dplca_claim_done = done_r;
    assign dplca_claim_lost = lost_r;

endmodule

// File: doc/dplca_txop_claim.md
Name: dplca_txop_claim

Overview:
- Claim-side (transmitter) counterpart to the DPLCA aging/learning machine. The aging machine observes claims and maintains txop_claim_table; this block reads that table and selects a free transmit-opportunity ID for the local node.
- It advertises that ID as a SOFT claim, promotes it to HARD after enough clean cycles, and abandons or re-selects on conflict.
- Sits beside the PLCA control state machine. Drives local_nodeID and the claim value carried in the local TXOP.

Parameters:
- SOFT_CYCLES, 4: consecutive conflict-free own TXOPs required before SOFT is promoted to HARD (1..255).
- LFSR_SEED, 8'hA5: reset value of the start-index LFSR (used only with the optional feature).

Ports:
- clk  in  1  block clock.
- rst_n  in  1  asynchronous, active-low reset.
- dplca_en  in  1  DPLCA enabled; 0 forces DISABLED.
- plca_node_count  in  8  number of TXOPs per cycle; valid IDs are 1..plca_node_count-1.
- dplca_txop_end  in  1  one-cycle pulse at the end of each observed TXOP.
- dplca_txop_id  in  8  ID of the TXOP that is ending; valid with dplca_txop_end.
- dplca_txop_collision  in  1  collision seen in the ending TXOP; valid with dplca_txop_end.
- dplca_txop_table_upd  in  1  one-cycle pulse: claim table has been refreshed.
- txop_claim_table_unpacked  in  512  256 x 2-bit entries; entry i occupies bits [2i+1:2i]. Encoding: SOFT=00, HARD=01, NONE=10.
- local_nodeID  out  8  claimed ID; 8'hFF when none.
- local_claim  out  2  claim advertised in the local TXOP (SOFT, HARD, NONE).
- claim_state  out  3  FSM state, for debug.
- dplca_claim_done  out  1  high while a HARD claim is held.
- dplca_claim_lost  out  1  one-cycle pulse when a held or candidate ID is abandoned.

Behaviour:
- Reset: state=DISABLED, local_nodeID=8'hFF, local_claim=NONE, claim_done=0, claim_lost=0, scan_idx=1, clean_cnt=0.
- FSM encoding: DISABLED=0, SCAN=1, WAIT_FREE=2, SOFT_CLAIM=3, HARD_CLAIM=4.
- dplca_en==0 in any state: DISABLED on the next clock, with the reset output values. This has priority over every other transition.
- DISABLED: when dplca_en=1, go to SCAN. scan_idx=1 (or the LFSR value with the option). Clear scan_cnt.
- SCAN: examine one entry per clock.
  - If table[scan_idx]==NONE: candidate=scan_idx. Drive local_nodeID=candidate, local_claim=SOFT. clean_cnt=0. Go to SOFT_CLAIM.
  - Otherwise advance scan_idx, wrapping from plca_node_count-1 back to 1. ID 0 is never selected.
  - After plca_node_count-1 entries are examined with no hit, go to WAIT_FREE.
  - plca_node_count<2: go straight to WAIT_FREE.
- WAIT_FREE: local_nodeID=8'hFF, local_claim=NONE. On dplca_txop_table_upd, go to SCAN.
- SOFT_CLAIM: on dplca_txop_end with dplca_txop_id==candidate:
  - collision=1: pulse claim_lost. Resume SCAN from candidate+1 (with wrap).
  - collision=0: clean_cnt+1. If it reaches SOFT_CYCLES: go to HARD_CLAIM, local_claim=HARD, claim_done=1.
  - Also on dplca_txop_table_upd, if table[candidate]==HARD (another node won): abandon exactly as for a collision.
  - table_upd and own txop_end in the same cycle: the collision/abandon result wins.
- HARD_CLAIM: hold the claim.
  - dplca_txop_end with id==candidate and collision=1: pulse claim_lost, claim_done=0. Go to SCAN from candidate+1.
  - Table contents are ignored here, because the node's own HARD claim is present in the table.
- clean_cnt is 8 bits and saturates at SOFT_CYCLES. IDs at or above plca_node_count are never scanned.
- Changing plca_node_count while a claim is held: if candidate >= plca_node_count, abandon (pulse claim_lost, go to SCAN).
- Outputs are registered: one clock from the decision to the visible output.

Optional Feature:
- Macro DPLCA_RANDOM_START_EN.
  - Defined: an 8-bit Galois LFSR (taps 8,6,5,4), seeded with LFSR_SEED, free-runs every clock. On entry to SCAN from DISABLED or WAIT_FREE, scan_idx = (lfsr mod (plca_node_count-1)) + 1. This spreads simultaneous joiners across IDs.
  - Not defined: scan always starts at 1 on those entries. Rescans after a conflict start at candidate+1 in both builds.

Decomposition:
- Shared package: claim encodings SOFT/HARD/NONE, TRUE/FALSE, ON/OFF, FSM state constants, NODE_ID_NONE=8'hFF.
- One sub-module, dplca_claim_lfsr: LFSR plus modulo-range reduction, instantiated only under DPLCA_RANDOM_START_EN.
- Table unpacking is an inline generate loop.

Test Plan:
- Table all NONE, node_count=8, SOFT_CYCLES=4, macro off → local_nodeID=1, SOFT. After 4 clean own TXOP ends: HARD, claim_done=1.
- Entries 1..3 HARD, 4 NONE → SCAN takes 4 clocks, then local_nodeID=4.
- SOFT on ID 2, collision at id 2 → claim_lost pulse, rescan from 3. If 3 is NONE, local_nodeID=3 with clean_cnt=0.
- All entries 1..7 HARD → WAIT_FREE, local_nodeID=FF, local_claim=NONE. Set entry 5 NONE and pulse table_upd → claim 5.
- HARD on ID 6, then dplca_en=0 mid-TXOP → next clock DISABLED, local_nodeID=FF, claim_done=0. Assert rst_n low during SOFT_CLAIM → immediate reset values.
- Macro on, seed A5, node_count=8 → first candidate equals the model's (lfsr%7)+1. Table_upd that shows the candidate HARD, arriving in the same cycle as a clean own txop_end → abandon wins.
